// File: rtl/reg_bank_arbiter_pkg.sv
// arb_pkg: shared FSM state type, default sizes and address decoder for reg_bank_arbiter.
package arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, WRITE, ACK} arb_state_t;
  localparam int NREQ_D = 4;
  localparam int WIDTH_D = 8;
  localparam int DEPTH_D = 4;
  localparam int MAX_AW = 8;
  localparam int MAX_DEPTH = 1 << MAX_AW;
  // Addresses at or beyond depth decode to all-zero so the write is dropped.
  function automatic logic [MAX_DEPTH-1:0] onehot_dec(input logic [MAX_AW-1:0] addr, input int unsigned depth);
    onehot_dec = '0;
    if (32'(addr) < depth) onehot_dec[addr] = 1'b1;
  endfunction
endpackage

// File: rtl/reg_bank_arbiter_if.sv
// reg_bank_arbiter_if: requester-side bus and register-bank write port of the arbiter.
interface reg_bank_arbiter_if #(
  parameter int NREQ = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2
);
  logic [NREQ-1:0] req;
  logic [NREQ*ADDR_W-1:0] wr_addr;
  logic [NREQ*WIDTH-1:0] wr_data;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] ack;
  logic [DEPTH-1:0] bank_we;
  logic [WIDTH-1:0] bank_d;
  logic busy;
  modport master (output req, wr_addr, wr_data, input gnt, ack, bank_we, bank_d, busy);
  modport slave (input req, wr_addr, wr_data, output gnt, ack, bank_we, bank_d, busy);
endinterface

// File: rtl/reg_bank_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set req bit starting at rr_ptr.
module rr_picker #(
  parameter int NREQ = 4,
  parameter int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            any
);
  int j;
  always_comb begin
    winner = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(rr_ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any = 1'b1;
        winner[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter feeding one register bank; ARB_FIXED_PRIO_EN gives requester 0 fixed priority.
import arb_pkg::*;
module reg_bank_arbiter #(
  parameter int NREQ = NREQ_D,
  parameter int WIDTH = WIDTH_D,
  parameter int DEPTH = DEPTH_D,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic clk,
  input logic rst_n,
  reg_bank_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  arb_state_t state, state_n;
  logic [NREQ-1:0] gnt_q, gnt_n, ack_q, ack_n, pick_req, pick_oh;
  logic [DEPTH-1:0] we_q, we_n;
  logic [WIDTH-1:0] d_q, d_n, data_q, data_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [IW-1:0] win_q, win_n, rr_q, rr_n, pick_idx, rr_next;
  logic busy_q, pick_any;
`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
  assign pick_req = bus.req[0] ? NREQ'(1) : bus.req;
`else
  localparam bit FIXED = 1'b0;
  assign pick_req = bus.req;
`endif
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req(pick_req), .rr_ptr(rr_q), .winner(pick_oh), .idx(pick_idx), .any(pick_any)
  );
  // Fixed-priority wins by requester 0 leave the rotation untouched.
  assign rr_next = (FIXED && win_q == '0) ? rr_q : (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
  always_comb begin
    state_n = state;
    gnt_n = gnt_q;
    ack_n = '0;
    we_n = '0;
    d_n = '0;
    addr_n = addr_q;
    data_n = data_q;
    win_n = win_q;
    rr_n = rr_q;
    case (state)
      IDLE: if (pick_any) begin
        state_n = GRANT;
        gnt_n = pick_oh;
        win_n = pick_idx;
        addr_n = bus.wr_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
        data_n = bus.wr_data[int'(pick_idx)*WIDTH +: WIDTH];
      end
      GRANT: if (bus.req[win_q]) begin
        state_n = WRITE;
        we_n = DEPTH'(onehot_dec(MAX_AW'(addr_q), DEPTH));
        d_n = data_q;
      end else begin
        state_n = IDLE;
        gnt_n = '0;
      end
      WRITE: begin
        state_n = ACK;
        ack_n = gnt_q;
      end
      default: begin
        state_n = IDLE;
        gnt_n = '0;
        rr_n = rr_next;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_q <= '0;
      ack_q <= '0;
      we_q <= '0;
      d_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      win_q <= '0;
      rr_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state <= state_n;
      gnt_q <= gnt_n;
      ack_q <= ack_n;
      we_q <= we_n;
      d_q <= d_n;
      addr_q <= addr_n;
      data_q <= data_n;
      win_q <= win_n;
      rr_q <= rr_n;
      busy_q <= (state_n != IDLE);
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.ack = ack_q;
  assign bus.bank_we = we_q;
  assign bus.bank_d = d_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed and randomized checks of reg_bank_arbiter against a transaction-level model.
module tb_reg_bank_arbiter;
  localparam int NREQ = 4;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int ADDR_W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  int rr = 0;
  logic [ADDR_W-1:0] addr [NREQ];
  logic [WIDTH-1:0] data [NREQ];
  reg_bank_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) bus ();
  reg_bank_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      bus.wr_addr[i*ADDR_W +: ADDR_W] = addr[i];
      bus.wr_data[i*WIDTH +: WIDTH] = data[i];
    end
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic int pick(input logic [NREQ-1:0] r, input int p);
`ifdef ARB_FIXED_PRIO_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  function automatic int advance(input int w, input int p);
`ifdef ARB_FIXED_PRIO_EN
    if (w == 0) return p;
`endif
    return (w + 1) % NREQ;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    check("we_ack_excl", {31'd0, (|bus.bank_we) && (|bus.ack)}, 32'd0);
  endtask
  task automatic run_txn(input int w, input bit drop);
    int a;
    int we;
    a = int'(addr[w]);
    we = (a < DEPTH) ? (1 << a) : 0;
    tick();
    check("gnt", 32'(bus.gnt), 1 << w);
    check("busy", 32'(bus.busy), 1);
    check("ack_early", 32'(bus.ack), 0);
    tick();
    check("bank_we", 32'(bus.bank_we), we);
    check("bank_d", 32'(bus.bank_d), 32'(data[w]));
    check("gnt_hold", 32'(bus.gnt), 1 << w);
    tick();
    check("ack", 32'(bus.ack), 1 << w);
    check("we_off", 32'(bus.bank_we), 0);
    if (drop) bus.req[w] = 1'b0;
    tick();
    check("idle_gnt", 32'(bus.gnt), 0);
    check("idle_busy", 32'(bus.busy), 0);
    rr = advance(w, rr);
  endtask
  task automatic withdraw(input int w);
    tick();
    check("wd_gnt", 32'(bus.gnt), 1 << w);
    bus.req[w] = 1'b0;
    tick();
    check("wd_gnt_off", 32'(bus.gnt), 0);
    check("wd_busy", 32'(bus.busy), 0);
    check("wd_we", 32'(bus.bank_we), 0);
    check("wd_ack", 32'(bus.ack), 0);
  endtask
  initial begin
    bus.req = '0;
    for (int i = 0; i < NREQ; i++) begin
      addr[i] = '0;
      data[i] = '0;
    end
    #2;
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_we", 32'(bus.bank_we), 0);
    check("rst_d", 32'(bus.bank_d), 0);
    check("rst_busy", 32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    bus.req = 4'b0100;
    addr[2] = 2'd3;
    data[2] = 8'hA5;
    run_txn(2, 1'b1);
    bus.req = 4'b0001;
    addr[0] = 2'd1;
    data[0] = 8'h3C;
    run_txn(0, 1'b1);
    bus.req = 4'b0010;
    withdraw(1);
    bus.req = 4'b1010;
    run_txn(1, 1'b1);
    bus.req = 4'b0001;
    addr[0] = 2'd2;
    data[0] = 8'h77;
    tick();
    tick();
    check("mid_we", 32'(bus.bank_we), 4);
    rst_n = 1'b0;
    #1;
    check("arst_we", 32'(bus.bank_we), 0);
    check("arst_gnt", 32'(bus.gnt), 0);
    check("arst_ack", 32'(bus.ack), 0);
    check("arst_busy", 32'(bus.busy), 0);
    bus.req = '0;
    rr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", 32'(bus.busy), 0);
    check("post_rst_gnt", 32'(bus.gnt), 0);
`ifdef ARB_FIXED_PRIO_EN
    bus.req = 4'b1011;
    for (int t = 0; t < 3; t++) run_txn(0, 1'b0);
    bus.req = 4'b1010;
    for (int t = 0; t < 4; t++) run_txn((t % 2 == 0) ? 1 : 3, 1'b0);
`else
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      addr[t % NREQ] = ADDR_W'(t);
      data[t % NREQ] = WIDTH'(8'h10 + t);
      run_txn(t % NREQ, 1'b0);
    end
`endif
    for (int t = 0; t < 40; t++) begin
      int w;
      bus.req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        addr[i] = ADDR_W'($urandom);
        data[i] = WIDTH'($urandom);
      end
      w = pick(bus.req, rr);
      if ($urandom_range(0, 4) == 0) withdraw(w);
      else run_txn(w, 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
